prog_loader: RTL and testbench

- Write-side counterpart of the instruction memory: fills the 25-bit instruction array from an 8-bit byte stream before execution starts.
- A host or test stream sends a word-count header byte, then 4 little-endian bytes per instruction.
- The block assembles each instruction word and issues one write per word to the instruction memory's write port.
- It reports busy, done and error status to the host.

---
 rtl/prog_loader.sv | 160 ++++++++++++++++
 tb/tb_prog_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader
//   Fills the instruction memory from an 8-bit byte stream. After a start
//   pulse the loader takes a word-count header byte N (1..DEPTH). It then
//   takes 4 little-endian bytes per instruction and issues one memory write
//   per assembled word, at addresses 0..N-1.
//
//   Optional build macro LOADER_CHECKSUM_EN: after the final write the loader
//   accepts one extra byte that must equal the XOR of all data bytes. A match
//   ends in DONE and a mismatch ends in ERR. The writes have already happened
//   by then, so ERR only marks the image as bad.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   start         one-cycle pulse; begins a load from IDLE, DONE or ERR
//   in_data       stream byte
//   in_valid      in_data valid this cycle
//   in_ready      loader accepts in_data this cycle
//   mem_we        one-cycle instruction memory write strobe
//   mem_addr      write address
//   mem_wdata     assembled instruction word
//   busy          load in progress
//   done          load completed successfully
//   err           load aborted on an error
module prog_loader #(
  parameter int DATA_W = 25,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    BYTE  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5,
    CSUM  = 3'd6
  } state_t;

  state_t            state, next_state;
  logic [7:0]        n_words;
  logic [ADDR_W-1:0] wcnt;
  logic [1:0]        bcnt;
  logic [31:0]       sreg;
  logic [31:0]       assembled;
  logic              xfer;
  logic              start_ok;
  logic              hdr_bad;
  logic              last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign start_ok  = start && (state == IDLE || state == DONE || state == ERR);
  assign xfer      = in_valid && in_ready;
  assign hdr_bad   = (in_data == 8'd0) || (in_data > 8'(DEPTH));
  // Incoming byte lands on top; after 4 bytes byte 0 sits in [7:0].
  assign assembled = {in_data, sreg[31:8]};
  assign last_word = (8'(wcnt) + 8'd1) >= n_words;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      HDR, BYTE: in_ready = 1'b1;
      CSUM:      in_ready = 1'b1;
      default:   in_ready = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERR: if (start_ok) next_state = HDR;
      HDR:   if (xfer) next_state = hdr_bad ? ERR : BYTE;
      BYTE:  if (xfer && bcnt == 2'd3)
               next_state = (assembled[31:DATA_W] != '0) ? ERR : WRITE;
`ifdef LOADER_CHECKSUM_EN
      WRITE: next_state = last_word ? CSUM : BYTE;
      CSUM:  if (xfer) next_state = (in_data == csum) ? DONE : ERR;
`else
      WRITE: next_state = last_word ? DONE : BYTE;
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_words <= '0;
      wcnt    <= '0;
      bcnt    <= '0;
      sreg    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      if (start_ok) begin
        wcnt <= '0;
        bcnt <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum <= '0;
`endif
      end
      if (state == HDR && xfer) n_words <= in_data;
      if (state == BYTE && xfer) begin
        sreg <= assembled;
        bcnt <= bcnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        csum <= csum ^ in_data;
`endif
      end
      // Address is captured below before the increment, so the address
      // bus only ever sees 0..N-1.
      if (state == WRITE) wcnt <= wcnt + 1'b1;
    end
  end

  // Outputs are registered one cycle behind the state: the strobe follows
  // WRITE and the status flags follow DONE/ERR. A start clears done/err on
  // the same edge at which it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= (state == WRITE);
      if (state == WRITE) begin
        mem_addr  <= wcnt;
        mem_wdata <= sreg[DATA_W-1:0];
      end
      busy <= start_ok || state == HDR || state == BYTE ||
              state == WRITE || state == CSUM;
      done <= (state == DONE) && !start_ok;
      err  <= (state == ERR) && !start_ok;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [24:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0]  wa [0:63];
  logic [24:0] wd [0:63];
  int          nw = 0;
  int          base;

  prog_loader #(.DATA_W(25), .ADDR_W(5), .DEPTH(25)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Write monitor: records every memory write strobe.
  always @(negedge clk) begin
    if (mem_we === 1'b1 && nw < 64) begin
      wa[nw] = mem_addr;
      wd[nw] = mem_wdata;
      nw = nw + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b);
    int k;
    in_data  = b;
    in_valid = 1'b1;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'hxx;
  endtask

  task automatic send_gap(input logic [7:0] b);
    int g;
    g = $urandom_range(0, 2);
    repeat (g) @(negedge clk);
    send_byte(b);
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    while (done !== 1'b1 && err !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (k >= 30) check("end_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    rst_n = 1'b1;

    // in_valid in IDLE without start is ignored
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    check("idle_rdy", 32'(in_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;

    // Two-word load
    base = nw;
    pulse_start();
    check("hdr_busy", 32'(busy), 32'd1);
    check("hdr_rdy", 32'(in_ready), 32'd1);
    send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h00);
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66); send_byte(8'h01);
`ifndef LOADER_CHECKSUM_EN
    check("lat_we0", 32'(mem_we), 32'd0);
    check("lat_rdy_write", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("lat_we1", 32'(mem_we), 32'd1);
    check("lat_done0", 32'(done), 32'd0);
    check("lat_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    check("lat_done1", 32'(done), 32'd1);
    check("lat_busy0", 32'(busy), 32'd0);
`else
    send_byte(8'h76);
    wait_end();
`endif
    @(negedge clk);
    check("t1_nw", 32'(nw - base), 32'd2);
    check("t1_a0", 32'(wa[base]), 32'd0);
    check("t1_d0", 32'(wd[base]), 32'h0332211);
    check("t1_a1", 32'(wa[base+1]), 32'd1);
    check("t1_d1", 32'(wd[base+1]), 32'h1665544);
    check("t1_done", 32'(done), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_rdy", 32'(in_ready), 32'd0);

    // Header 0
    base = nw;
    pulse_start();
    check("h0_done_clr", 32'(done), 32'd0);
    send_byte(8'h00);
    @(negedge clk);
    check("h0_err", 32'(err), 32'd1);
    check("h0_rdy", 32'(in_ready), 32'd0);
    check("h0_busy", 32'(busy), 32'd0);
    check("h0_nw", 32'(nw - base), 32'd0);

    // Header 26 (one past DEPTH)
    base = nw;
    pulse_start();
    check("h26_err_clr", 32'(err), 32'd0);
    send_byte(8'h1A);
    @(negedge clk);
    check("h26_err", 32'(err), 32'd1);
    check("h26_rdy", 32'(in_ready), 32'd0);
    check("h26_nw", 32'(nw - base), 32'd0);

    // Header 25 (DEPTH) is accepted
    pulse_start();
    send_byte(8'h19);
    @(negedge clk);
    check("h25_err", 32'(err), 32'd0);
    check("h25_rdy", 32'(in_ready), 32'd1);

    // Upper bits set -> error, no write
    base = nw;
    pulse_start(); // ignored: load in progress
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
    repeat (3) @(negedge clk);
    check("b25_err", 32'(err), 32'd1);
    check("b25_done", 32'(done), 32'd0);
    check("b25_nw", 32'(nw - base), 32'd0);

    // Three words with gaps and ignored starts
    base = nw;
    pulse_start();
    send_gap(8'h03);
    send_gap(8'h01); send_gap(8'h02); send_gap(8'h03); send_gap(8'h00);
    pulse_start();
    send_gap(8'hAA); send_gap(8'hBB); send_gap(8'hCC); send_gap(8'h01);
    pulse_start();
    send_gap(8'h10); send_gap(8'h32); send_gap(8'h54); send_gap(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_gap(8'hAA);
`endif
    wait_end();
    @(negedge clk);
    check("t5_nw", 32'(nw - base), 32'd3);
    check("t5_a0", 32'(wa[base]), 32'd0);
    check("t5_d0", 32'(wd[base]), 32'h0030201);
    check("t5_a1", 32'(wa[base+1]), 32'd1);
    check("t5_d1", 32'(wd[base+1]), 32'h1CCBBAA);
    check("t5_a2", 32'(wa[base+2]), 32'd2);
    check("t5_d2", 32'(wd[base+2]), 32'h0543210);
    check("t5_done", 32'(done), 32'd1);
    check("t5_err", 32'(err), 32'd0);

    // Reset after 5 data bytes
    base = nw;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'h00);
    send_byte(8'h12);
    rst_n = 1'b0;
    #1;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    check("mr_err", 32'(err), 32'd0);
    check("mr_rdy", 32'(in_ready), 32'd0);
    check("mr_we", 32'(mem_we), 32'd0);
    check("mr_addr", 32'(mem_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mr_nw", 32'(nw - base), 32'd1);
    base = nw;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h1A);
`endif
    wait_end();
    @(negedge clk);
    check("rl_nw", 32'(nw - base), 32'd1);
    check("rl_a0", 32'(wa[base]), 32'd0);
    check("rl_d0", 32'(wd[base]), 32'h0345678);
    check("rl_done", 32'(done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    base = nw;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h00);
    repeat (2) @(negedge clk);
    check("cs_rdy", 32'(in_ready), 32'd1);
    check("cs_busy", 32'(busy), 32'd1);
    send_byte(8'h07);
    check("cs_done_lat", 32'(done), 32'd0);
    @(negedge clk);
    check("cs_done", 32'(done), 32'd1);
    check("cs_err", 32'(err), 32'd0);
    check("cs_d0", 32'(wd[base]), 32'h0040201);

    base = nw;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h00);
    send_byte(8'h06);
    @(negedge clk);
    check("csb_err", 32'(err), 32'd1);
    check("csb_done", 32'(done), 32'd0);
    check("csb_nw", 32'(nw - base), 32'd1);
    check("csb_a0", 32'(wa[base]), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
